// File: rtl/uart_rx_frame_pkg.sv
// Shared constants and state types for the UART frame receiver (package uart_pkg).
package uart_pkg;
    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;
    localparam logic [7:0] SYNC0 = 8'hAA;
    localparam logic [7:0] SYNC1 = 8'h55;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD} frame_state_e;
endpackage

// File: rtl/uart_rx_frame_if.sv
// Serial input, pixel-RAM write port, frame status and FSM debug state of the frame receiver.
// Handshake: we is a one-cycle strobe with no back-pressure; wAddr/wData are valid only while we=1.
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 14
);
    logic                  rx;
    logic                  b_16tick;
    logic                  we;
    logic [ADDR_WIDTH-1:0] wAddr;
    logic [DATA_WIDTH-1:0] wData;
    logic                  frame_busy;
    logic                  frame_done;
    logic                  frame_err;
    logic [1:0]            rx_state;
    logic [1:0]            frame_state;

    modport slave (
        input  rx, b_16tick,
        output we, wAddr, wData, frame_busy, frame_done, frame_err, rx_state, frame_state
    );
    modport master (
        output rx, b_16tick,
        input  we, wAddr, wData, frame_busy, frame_done, frame_err, rx_state, frame_state
    );
endinterface

// File: rtl/uart_rx_frame_core.sv
// uart_rx_core: rx synchroniser plus 16x-oversampled 8N1 bit sampler; one-cycle byte_valid/byte_err.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_i,
    input  logic                  tick_i,
    output logic [DATA_WIDTH-1:0] byte_o,
    output logic                  byte_valid_o,
    output logic                  byte_err_o,
    output logic [1:0]            state_o
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rx_meta_q, rx_sync_q;
    rx_state_e             state_q, state_d;
    logic [3:0]            tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  stop_sample;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            rx_meta_q  <= rx_i;
            rx_sync_q  <= rx_meta_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d    = START;
                    tick_cnt_d = '0;
                end
            end
            START: begin
                if (tick_i) begin
                    if (tick_cnt_q == 4'(MID_SAMPLE - 1)) begin
                        // Line back high at mid-start means a glitch, not a character.
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_sync_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick_i) begin
                    if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) state_d = STOP;
                        else                                   bit_cnt_d = bit_cnt_q + 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick_i) begin
                    if (tick_cnt_q == 4'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stop_sample  = (state_q == STOP) && tick_i && (tick_cnt_q == 4'(OVERSAMPLE - 1));
        byte_valid_o = stop_sample && rx_sync_q;
        byte_err_o   = stop_sample && !rx_sync_q;
        byte_o       = shift_q;
        state_o      = state_q;
    end
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: finds the AA 55 sync header and writes TOTAL_PIXELS payload bytes to the pixel RAM.
// Optional idle-timeout abort while receiving payload is enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IMG_WIDTH    = 80,
    parameter int IMG_HEIGHT   = 120,
    parameter int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT,
    parameter int ADDR_WIDTH   = $clog2(TOTAL_PIXELS),
    parameter int TIMEOUT_TCKS = 16 * 10 * 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_frame_if.slave bus
);
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  byte_valid, byte_err, timeout;
    logic [1:0]            core_state;

    frame_state_e          fstate_q, fstate_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d, done_q, done_d, err_q, err_d;

    uart_rx_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (bus.rx),
        .tick_i       (bus.b_16tick),
        .byte_o       (rx_byte),
        .byte_valid_o (byte_valid),
        .byte_err_o   (byte_err),
        .state_o      (core_state)
    );

`ifdef UART_RX_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_TCKS + 1);
    logic [IW-1:0] idle_q, idle_d;

    always_ff @(posedge clk) begin
        if (reset) idle_q <= '0;
        else       idle_q <= idle_d;
    end

    always_comb begin
        idle_d = idle_q;
        if (fstate_q != PAYLOAD || byte_valid) idle_d = '0;
        else if (bus.b_16tick)                 idle_d = idle_q + 1'b1;
        timeout = (fstate_q == PAYLOAD) && bus.b_16tick && !byte_valid &&
                  (idle_q == IW'(TIMEOUT_TCKS - 1));
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            fstate_q <= HDR0;
            count_q  <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fstate_q <= fstate_d;
            count_q  <= count_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        fstate_d = fstate_q;
        count_d  = count_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        err_d    = 1'b0;
        // The last write strobe is already registered, so done lands exactly one cycle after it.
        done_d   = we_q && (waddr_q == ADDR_WIDTH'(TOTAL_PIXELS - 1));
        case (fstate_q)
            HDR0: begin
                if (byte_err)                         err_d = 1'b1;
                else if (byte_valid && rx_byte == SYNC0) fstate_d = HDR1;
            end
            HDR1: begin
                if (byte_err) begin
                    err_d    = 1'b1;
                    fstate_d = HDR0;
                end else if (byte_valid) begin
                    if (rx_byte == SYNC1) begin
                        fstate_d = PAYLOAD;
                        count_d  = '0;
                    end else if (rx_byte != SYNC0) begin
                        fstate_d = HDR0;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_err || timeout) begin
                    err_d    = 1'b1;
                    count_d  = '0;
                    fstate_d = HDR0;
                end else if (byte_valid) begin
                    we_d    = 1'b1;
                    waddr_d = count_q;
                    wdata_d = rx_byte;
                    if (count_q == ADDR_WIDTH'(TOTAL_PIXELS - 1)) begin
                        count_d  = '0;
                        fstate_d = HDR0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: fstate_d = HDR0;
        endcase
    end

    always_comb begin
        bus.we          = we_q;
        bus.wAddr       = waddr_q;
        bus.wData       = wdata_q;
        bus.frame_busy  = (fstate_q == PAYLOAD);
        bus.frame_done  = done_q;
        bus.frame_err   = err_q;
        bus.rx_state    = core_state;
        bus.frame_state = fstate_q;
    end
endmodule
